// File: rtl/pipeline_pkg.sv
// Shared opcode/size encodings, FSM state type and small datapath helpers
// for the MEM pipeline stage.
package pipeline_pkg;

    localparam logic [31:0] OPC_NONE  = 32'd0;
    localparam logic [31:0] OPC_LOAD  = 32'd1;
    localparam logic [31:0] OPC_STORE = 32'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_STORE} mem_op_e;

    // Unknown opcodes fall back to NONE.
    function automatic mem_op_e decode_op(input logic [31:0] opc);
        case (opc)
            OPC_NONE:  return OP_NONE;
            OPC_LOAD:  return OP_LOAD;
            OPC_STORE: return OP_STORE;
            default:   return OP_NONE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] d);
        case (size)
            SZ_B:    return {8{d[7:0]}};
            SZ_H:    return {4{d[15:0]}};
            SZ_W:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed lane from a 64-bit read word and sign/zero-extends it.
module mem_load_align
    import pipeline_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [63:0] data
);

    logic [63:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        data = lane;
        case (size)
            SZ_B:    data = zext ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            SZ_H:    data = zext ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SZ_W:    data = zext ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: issues aligned loads/stores to data memory, short-circuits
// NONE and misaligned ops, and presents a one-cycle writeback pulse.
module pipeline_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           mem_opcode,
    input  logic [2:0]            mem_operation_size,
    input  logic                  ecall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [63:0]           dmem_wdata,
    output logic [7:0]            dmem_wstrb,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [63:0]           dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_dst_reg,
    output logic                  wb_ecall,
    output logic                  wb_misaligned
);

    state_e      state, state_nxt;
    mem_op_e     in_op, op_q;
    logic        in_misal, accept, start_mem, fast_done;
    logic [4:0]  dst_q;
    logic        ecall_q, zext_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] load_data;

    assign in_op     = decode_op(mem_opcode);
    assign in_misal  = (in_op != OP_NONE) && is_misaligned(mem_operation_size[1:0], ex_res[2:0]);
    assign accept    = in_valid && ready;
    assign start_mem = accept && (in_op != OP_NONE) && !in_misal;
    assign fast_done = accept && !start_mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mem) state_nxt = REQ;
            REQ:     if (dmem_gnt) state_nxt = (op_q == OP_STORE) ? RESP : WAIT;
            WAIT:    if (dmem_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == IDLE);
        dmem_req = (state == REQ);
        dmem_we  = (state == REQ) && (op_q == OP_STORE);
    end

    mem_load_align u_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .size   (size_q),
        .zext   (zext_q),
        .data   (load_data)
    );

    // wb_* is loaded either at accept (single-cycle ops) or on entry to RESP,
    // so wb_valid is a registered pulse in both paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= OP_NONE;
            dst_q         <= '0;
            ecall_q       <= 1'b0;
            zext_q        <= 1'b0;
            size_q        <= '0;
            off_q         <= '0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_wstrb    <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_dst_reg    <= '0;
            wb_ecall      <= 1'b0;
            wb_misaligned <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (fast_done) begin
                wb_valid      <= 1'b1;
                wb_data       <= in_misal ? '0 : ex_res;
                wb_dst_reg    <= in_misal ? 5'd0 : mem_dst_reg;
                wb_ecall      <= ecall;
                wb_misaligned <= in_misal;
            end
            if (start_mem) begin
                op_q       <= in_op;
                dst_q      <= mem_dst_reg;
                ecall_q    <= ecall;
                zext_q     <= mem_operation_size[2];
                size_q     <= mem_operation_size[1:0];
                off_q      <= ex_res[2:0];
                dmem_addr  <= {ex_res[ADDR_WIDTH-1:3], 3'b000};
                dmem_wdata <= replicate(mem_operation_size[1:0], r2_val_mem);
                dmem_wstrb <= size_mask(mem_operation_size[1:0]) << ex_res[2:0];
            end
            if (state == REQ && dmem_gnt && op_q == OP_STORE) begin
                wb_valid      <= 1'b1;
                wb_data       <= '0;
                wb_dst_reg    <= 5'd0;
                wb_ecall      <= ecall_q;
                wb_misaligned <= 1'b0;
            end
            if (state == WAIT && dmem_rvalid) begin
                wb_valid      <= 1'b1;
                wb_data       <= load_data;
                wb_dst_reg    <= dst_q;
                wb_ecall      <= ecall_q;
                wb_misaligned <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem.sv
// Self-checking bench for pipeline_mem: scoreboard of expected writebacks,
// popped by a monitor whenever wb_valid is seen.
module tb_pipeline_mem;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, ready;
    logic [63:0] ex_res, r2_val_mem;
    logic [4:0]  mem_dst_reg;
    logic [31:0] mem_opcode;
    logic [2:0]  mem_operation_size;
    logic        ecall;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_dst_reg;
    logic        wb_ecall, wb_misaligned;

    pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
        .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
        .mem_opcode(mem_opcode), .mem_operation_size(mem_operation_size), .ecall(ecall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_dst_reg(wb_dst_reg), .wb_ecall(wb_ecall),
        .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_data;
        logic [63:0] data;
        logic [4:0]  dst;
        logic        ecall;
        logic        misal;
    } wb_exp_t;

    typedef struct {
        logic [2:0]  sz;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [63:0] exp;
    } ld_t;

    typedef struct {
        logic [2:0]  sz;
        logic [63:0] addr;
        logic [63:0] r2;
        int          delay;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } st_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid with data=%h dst=%0d, required no writeback",
                         wb_data, wb_dst_reg);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_dst_reg !== mon_e.dst || wb_ecall !== mon_e.ecall ||
                    wb_misaligned !== mon_e.misal || (mon_e.chk_data && wb_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL wb_result: got data=%h dst=%0d ecall=%b mis=%b, required data=%h dst=%0d ecall=%b mis=%b",
                             wb_data, wb_dst_reg, wb_ecall, wb_misaligned,
                             mon_e.data, mon_e.dst, mon_e.ecall, mon_e.misal);
                end
            end
        end
    end

    task automatic drive_op(input logic [31:0] opc, input logic [2:0] sz, input logic [63:0] addr,
                            input logic [63:0] r2, input logic [4:0] dst, input logic ec);
        in_valid           = 1'b1;
        mem_opcode         = opc;
        mem_operation_size = sz;
        ex_res             = addr;
        r2_val_mem         = r2;
        mem_dst_reg        = dst;
        ecall              = ec;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({ready, dmem_req, dmem_we, wb_valid, wb_ecall, wb_misaligned, wb_dst_reg} !== 11'b100_0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b req=%b we=%b wbv=%b ec=%b mis=%b dst=%0d, required rdy=1 others 0",
                     ready, dmem_req, dmem_we, wb_valid, wb_ecall, wb_misaligned, wb_dst_reg);
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, dmem_wstrb, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h wbdata=%h, required all 0",
                     dmem_addr, dmem_wdata, dmem_wstrb, wb_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_none();
        exp_q.push_back('{chk_data: 1'b1, data: 64'h1234, dst: 5'd5, ecall: 1'b0, misal: 1'b0});
        drive_op(OPC_NONE, 3'd3, 64'h1234, 64'h0, 5'd5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL none_latency: got wbv=%b req=%b rdy=%b, required 1/0/1", wb_valid, dmem_req, ready);
        end
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL none_pulse: got wb_valid=%b, required 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opcs [4];
        opcs[0] = OPC_NONE; opcs[1] = 32'd7; opcs[2] = OPC_NONE; opcs[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_checks++;
                if (wb_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_valid_%0d: got wb_valid=%b, required 1", i, wb_valid);
                end
            end
            exp_q.push_back('{chk_data: 1'b1, data: 64'h1111 * (i + 1), dst: 5'(i + 1),
                              ecall: (i == 2), misal: 1'b0});
            drive_op(opcs[i], 3'd0, 64'h1111 * (i + 1), 64'h0, 5'(i + 1), (i == 2));
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_last: got wb_valid=%b, required 1", wb_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_loads();
        ld_t tab [6];
        tab[0] = '{3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        tab[1] = '{3'b110, 64'h4004, 64'hF000_0000_0000_0000, 64'h0000_0000_F000_0000};
        tab[2] = '{3'b001, 64'h5002, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
        tab[3] = '{3'b111, 64'h5008, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
        tab[4] = '{3'b100, 64'h50FF, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5};
        tab[5] = '{3'b010, 64'h6000, 64'h0000_0000_8765_4321, 64'hFFFF_FFFF_8765_4321};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{chk_data: 1'b1, data: tab[i].exp, dst: 5'(10 + i), ecall: 1'b0, misal: 1'b0});
            drive_op(OPC_LOAD, tab[i].sz, tab[i].addr, 64'h0, 5'(10 + i), 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {tab[i].addr[63:3], 3'b000}) begin
                n_fail++;
                $display("FAIL load_req_%0d: got req=%b we=%b addr=%h, required 1/0/%h",
                         i, dmem_req, dmem_we, dmem_addr, {tab[i].addr[63:3], 3'b000});
            end
            dmem_gnt = 1'b1;
            if (i == 1) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = ~tab[i].rdata;
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            n_checks++;
            if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_wait_%0d: got req=%b wbv=%b rdy=%b, required 0/0/0", i, dmem_req, wb_valid, ready);
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = tab[i].rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            n_checks++;
            if (wb_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL load_latency_%0d: got wb_valid=%b, required 1", i, wb_valid);
            end
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_idle_%0d: got rdy=%b wbv=%b, required 1/0", i, ready, wb_valid);
            end
        end
    endtask

    task automatic test_stores();
        st_t tab [4];
        tab[0] = '{3'b001, 64'h2006, 64'h0000_0000_0000_ABCD, 3, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0};
        tab[1] = '{3'b010, 64'h7004, 64'h1122_3344_5566_7788, 0, 64'h5566_7788_5566_7788, 8'hF0};
        tab[2] = '{3'b000, 64'h7001, 64'hFFFF_FFFF_FFFF_FF5A, 1, 64'h5A5A_5A5A_5A5A_5A5A, 8'h02};
        tab[3] = '{3'b011, 64'h7008, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{chk_data: 1'b0, data: 64'h0, dst: 5'd0, ecall: (i == 2), misal: 1'b0});
            drive_op(OPC_STORE, tab[i].sz, tab[i].addr, tab[i].r2, 5'(20 + i), (i == 2));
            @(negedge clk);
            in_valid = 1'b0;
            for (int d = 0; d <= tab[i].delay; d++) begin
                n_checks++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {tab[i].addr[63:3], 3'b000} ||
                    dmem_wdata !== tab[i].wdata || dmem_wstrb !== tab[i].wstrb) begin
                    n_fail++;
                    $display("FAIL store_req_%0d_%0d: got req=%b we=%b addr=%h wdata=%h wstrb=%h, required 1/1/%h/%h/%h",
                             i, d, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
                             {tab[i].addr[63:3], 3'b000}, tab[i].wdata, tab[i].wstrb);
                end
                dmem_gnt = (d == tab[i].delay);
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            n_checks++;
            if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL store_resp_%0d: got wbv=%b req=%b we=%b, required 1/0/0", i, wb_valid, dmem_req, dmem_we);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] opcs [3];
        logic [2:0]  szs  [3];
        logic [63:0] adrs [3];
        opcs[0] = OPC_LOAD;  szs[0] = 3'b010; adrs[0] = 64'h3002;
        opcs[1] = OPC_STORE; szs[1] = 3'b011; adrs[1] = 64'h3004;
        opcs[2] = OPC_LOAD;  szs[2] = 3'b101; adrs[2] = 64'h3001;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{chk_data: 1'b0, data: 64'h0, dst: 5'd0, ecall: (i == 1), misal: 1'b1});
            drive_op(opcs[i], szs[i], adrs[i], 64'hDEAD, 5'(3 + i), (i == 1));
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL misaligned_%0d: got req=%b wbv=%b rdy=%b, required 0/1/1", i, dmem_req, wb_valid, ready);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        drive_op(OPC_LOAD, 3'b011, 64'h6000, 64'h0, 5'd17, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        reset    = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b1 || dmem_req !== 1'b0 || dmem_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_async: got rdy=%b req=%b addr=%h, required 1/0/0", ready, dmem_req, dmem_addr);
        end
        @(negedge clk);
        reset       = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (wb_valid !== 1'b0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL late_rvalid_%0d: got wbv=%b rdy=%b, required 0/1", k, wb_valid, ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; ex_res = '0; r2_val_mem = '0; mem_dst_reg = '0;
        mem_opcode = '0; mem_operation_size = '0; ecall = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        test_reset();
        test_none();
        test_back_to_back();
        test_loads();
        test_stores();
        test_misaligned();
        test_reset_in_wait();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
